branch_hazard_controller: RTL and testbench
===========================================

BRANCH_HAZARD_CONTROLLER -- requirements
Module: branch_hazard_controller

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port id_branch, input, 1, instruction in ID is a branch compared in ID.
REQ-004 SHALL have ports id_rs and id_rt, input, 5 each, source registers of the ID instruction.
REQ-005 SHALL have ports id_use_rs and id_use_rt, input, 1 each, ID instruction actually reads rs or rt.
REQ-006 SHALL have ports id_ex_dst, id_ex_write and id_ex_memread, input, 5/1/1, destination, write-enable and load flag of the ID/EX instruction.
REQ-007 SHALL have ports ex_mem_dst, ex_mem_write and ex_mem_memread, input, 5/1/1, the same fields for the EX/MEM instruction.
REQ-008 SHALL have port branch_taken, input, 1, ID comparator result, valid when id_branch=1.
REQ-009 SHALL have ports pc_write and if_id_write, output, 1 each, PC and IF/ID register enables.
REQ-010 SHALL have port id_ex_bubble, output, 1, zeroes the ID/EX control fields.
REQ-011 SHALL have port if_id_flush, output, 1, clears IF/ID on a taken branch.
REQ-012 SHALL have ports stall_cycles and flush_count, output, 16 each, saturating performance counters.

Function
REQ-013 SHALL treat a source as matching a producer only if the source is used, producer write=1, dst equals source and dst is not 5'd0.
REQ-014 SHALL compute need=2 when id_branch=1 and a source matches an ID/EX producer with memread=1.
REQ-015 SHALL compute need=1, unless need=2 applies, when id_branch=1 and a source matches an ID/EX producer with memread=0, or a source matches an EX/MEM producer with memread=1.
REQ-016 SHALL compute need=1 when id_branch=0 and a source matches an ID/EX producer with memread=1 (load-use).
REQ-017 SHALL compute need=0 in all other cases; EX/MEM ALU results and MEM/WB results are forwarded and never stall.
REQ-018 SHALL implement states RUN and HOLD, with a 1-bit remain register.
REQ-019 In RUN, stall SHALL equal (need!=0), evaluated combinationally in the same cycle.
REQ-020 In RUN with need=2, the block SHALL go to HOLD with remain=1; with need of 0 or 1, it SHALL stay in RUN.
REQ-021 In HOLD, stall SHALL be 1 unconditionally, need SHALL be ignored, and the block SHALL return to RUN next cycle.
REQ-022 Outputs SHALL be pc_write=~stall, if_id_write=~stall and id_ex_bubble=stall.
REQ-023 if_id_flush SHALL equal id_branch & branch_taken & ~stall; a stalled branch SHALL never flush.
REQ-024 stall_cycles SHALL increment by 1 on each clock edge where stall=1, and SHALL saturate at 16'hFFFF with no wrap.
REQ-025 flush_count SHALL increment by 1 on each clock edge where if_id_flush=1, and SHALL saturate at 16'hFFFF.
REQ-026 When both rs and rt hazards exist, the larger need SHALL apply and the stall SHALL not be summed.

Reset
REQ-027 Asserting reset SHALL immediately force state=RUN, remain=0, stall_cycles=0 and flush_count=0, independent of clk.
REQ-028 While reset is high, outputs SHALL be pc_write=1, if_id_write=1, id_ex_bubble=0 and if_id_flush=0.
REQ-029 Reset asserted during HOLD SHALL abandon the remaining stall; the first cycle after release SHALL evaluate in RUN.

Verification
REQ-030 ALU hazard: lw-free add r5 in ID/EX, beq r5,r0 in ID -> one cycle stall=1 (pc_write=0, id_ex_bubble=1), then no stall; stall_cycles=1.
REQ-031 Load into branch: lw r7 in ID/EX (memread=1), beq r7,r2 in ID -> exactly 2 consecutive stall cycles, then with branch_taken=1 -> if_id_flush=1 for 1 cycle; stall_cycles=2, flush_count=1.
REQ-032 Zero register: id_ex_dst=0 with id_ex_write=1 and memread=1, beq r0,r0 -> no stall, pc_write=1 throughout.
REQ-033 Load-use on non-branch: lw r3 in ID/EX, add using r3 in ID -> 1 stall cycle; the same with id_use_rt=0 and rt=3 only -> no stall.
REQ-034 Saturation: preload stall_cycles to 16'hFFFE via 2 final stall cycles -> the counter reads 16'hFFFF and holds after further stalls.
REQ-035 Mid-HOLD reset: reset pulse in the second stall cycle of the load-branch case -> immediate pc_write=1 and counters=0, with RUN evaluation after release.

Source files
------------

// File: rtl/branch_hazard_controller.sv
// Branch/load-use hazard detection for a 5-stage pipeline with branches resolved in ID.
// Produces PC/IF-ID enables, ID/EX bubble, taken-branch flush and saturating perf counters.

module branch_hazard_src (
  input  logic       use_src,
  input  logic [4:0] src,
  input  logic [4:0] dst,
  input  logic       wr,
  output logic       hit
);
  assign hit = use_src & wr & (dst == src) & (dst != 5'd0);
endmodule

module branch_hazard_controller #(
  parameter int NUM_SRC  = 2,
  parameter int NUM_PROD = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_branch,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  id_ex_dst,
  input  logic        id_ex_write,
  input  logic        id_ex_memread,
  input  logic [4:0]  ex_mem_dst,
  input  logic        ex_mem_write,
  input  logic        ex_mem_memread,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  typedef struct packed {
    logic [4:0] dst;
    logic       wr;
    logic       memread;
  } prod_t;

  logic [NUM_SRC-1:0][4:0]           src;
  logic [NUM_SRC-1:0]                src_use;
  prod_t [NUM_PROD-1:0]              prod;
  logic [NUM_PROD-1:0][NUM_SRC-1:0]  hit;

  // producer 0 = ID/EX, producer 1 = EX/MEM
  assign src     = {id_rt, id_rs};
  assign src_use = {id_use_rt, id_use_rs};
  assign prod[0] = '{dst: id_ex_dst,  wr: id_ex_write,  memread: id_ex_memread};
  assign prod[1] = '{dst: ex_mem_dst, wr: ex_mem_write, memread: ex_mem_memread};

  for (genvar p = 0; p < NUM_PROD; p++) begin : g_prod
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      branch_hazard_src u_match (
        .use_src (src_use[s]),
        .src     (src[s]),
        .dst     (prod[p].dst),
        .wr      (prod[p].wr),
        .hit     (hit[p][s])
      );
    end
  end

  logic       ex_ld, ex_alu, mem_ld;
  logic [1:0] need;
  logic [0:0] state;
  logic       remain;
  logic       stall;

  assign ex_ld  = (|hit[0]) &  prod[0].memread;
  assign ex_alu = (|hit[0]) & ~prod[0].memread;
  assign mem_ld = (|hit[1]) &  prod[1].memread;

  // Per-source hits are OR-reduced, so rs and rt hazards take the max need rather than summing.
  always_comb begin
    need = 2'd0;
    if (id_branch & ex_ld)
      need = 2'd2;
    else if ((id_branch & (ex_alu | mem_ld)) | (~id_branch & ex_ld))
      need = 2'd1;
  end

  assign stall        = ~reset & ((state == HOLD) | remain | (need != 2'd0));
  assign pc_write     = ~stall;
  assign if_id_write  = ~stall;
  assign id_ex_bubble = stall;
  assign if_id_flush  = ~reset & id_branch & branch_taken & ~stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      remain <= 1'b0;
    end else if (state == HOLD) begin
      state  <= RUN;
      remain <= 1'b0;
    end else if (need == 2'd2) begin
      state  <= HOLD;
      remain <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else begin
      if (stall && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (if_id_flush && flush_count != 16'hFFFF)
        flush_count <= flush_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_branch_hazard_controller.sv
// Directed bench for branch_hazard_controller: hazard cases, HOLD behaviour, reset and counter saturation.

module tb_branch_hazard_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic        id_branch, id_use_rs, id_use_rt;
  logic [4:0]  id_rs, id_rt, id_ex_dst, ex_mem_dst;
  logic        id_ex_write, id_ex_memread, ex_mem_write, ex_mem_memread;
  logic        branch_taken;
  logic        pc_write, if_id_write, id_ex_bubble, if_id_flush;
  logic [15:0] stall_cycles, flush_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_hazard_controller dut (
    .clk            (clk),
    .reset          (reset),
    .id_branch      (id_branch),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_use_rs      (id_use_rs),
    .id_use_rt      (id_use_rt),
    .id_ex_dst      (id_ex_dst),
    .id_ex_write    (id_ex_write),
    .id_ex_memread  (id_ex_memread),
    .ex_mem_dst     (ex_mem_dst),
    .ex_mem_write   (ex_mem_write),
    .ex_mem_memread (ex_mem_memread),
    .branch_taken   (branch_taken),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .id_ex_bubble   (id_ex_bubble),
    .if_id_flush    (if_id_flush),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks the stall-related outputs as a group; st is the expected stall.
  task automatic chk_stall(input string tag, input logic st);
    chk({tag, ".pc_write"},     {15'd0, pc_write},     {15'd0, ~st});
    chk({tag, ".if_id_write"},  {15'd0, if_id_write},  {15'd0, ~st});
    chk({tag, ".id_ex_bubble"}, {15'd0, id_ex_bubble}, {15'd0, st});
  endtask

  task automatic clr();
    id_branch = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_ex_dst = 0; id_ex_write = 0; id_ex_memread = 0;
    ex_mem_dst = 0; ex_mem_write = 0; ex_mem_memread = 0;
    branch_taken = 0;
  endtask

  task automatic load_branch_inputs();
    clr();
    id_ex_dst = 5'd7; id_ex_write = 1; id_ex_memread = 1;
    id_branch = 1; id_rs = 5'd7; id_rt = 5'd2; id_use_rs = 1; id_use_rt = 1;
    branch_taken = 1;
  endtask

  initial begin
    clr();
    reset = 1;
    #1;
    chk_stall("reset", 1'b0);
    chk("reset.flush", {15'd0, if_id_flush}, 16'd0);
    chk("reset.stall_cycles", stall_cycles, 16'd0);
    chk("reset.flush_count", flush_count, 16'd0);
    // a hazard while reset is high must not stall or flush
    load_branch_inputs();
    #1;
    chk_stall("reset_hazard", 1'b0);
    chk("reset_hazard.flush", {15'd0, if_id_flush}, 16'd0);
    @(negedge clk);
    clr();
    reset = 0;

    // ALU producer feeding a branch: one stall, then forwarded from EX/MEM
    @(negedge clk);
    id_ex_dst = 5'd5; id_ex_write = 1;
    id_branch = 1; id_rs = 5'd5; id_rt = 5'd0; id_use_rs = 1; id_use_rt = 1;
    #1 chk_stall("alu_br.c0", 1'b1);
    @(negedge clk);
    chk("alu_br.stall_cycles", stall_cycles, 16'd1);
    id_ex_dst = 0; id_ex_write = 0;
    ex_mem_dst = 5'd5; ex_mem_write = 1;
    #1 chk_stall("alu_br.c1", 1'b0);
    @(negedge clk);
    chk("alu_br.stall_cycles_hold", stall_cycles, 16'd1);

    // load into taken branch: two stalls, second ignores need, then a single flush
    clr();
    load_branch_inputs();
    #1 chk_stall("ld_br.c0", 1'b1);
    chk("ld_br.c0.flush", {15'd0, if_id_flush}, 16'd0);
    @(negedge clk);
    id_ex_dst = 0; id_ex_write = 0; id_ex_memread = 0;
    #1 chk_stall("ld_br.hold", 1'b1);
    chk("ld_br.hold.flush", {15'd0, if_id_flush}, 16'd0);
    @(negedge clk);
    #1 chk_stall("ld_br.c2", 1'b0);
    chk("ld_br.c2.flush", {15'd0, if_id_flush}, 16'd1);
    @(negedge clk);
    id_branch = 0;
    #1 chk("ld_br.c3.flush", {15'd0, if_id_flush}, 16'd0);
    chk("ld_br.stall_cycles", stall_cycles, 16'd3);
    chk("ld_br.flush_count", flush_count, 16'd1);

    // zero register destination never matches
    clr();
    id_ex_dst = 0; id_ex_write = 1; id_ex_memread = 1;
    id_branch = 1; id_use_rs = 1; id_use_rt = 1;
    #1 chk_stall("zero.c0", 1'b0);
    @(negedge clk);
    #1 chk_stall("zero.c1", 1'b0);

    // load-use on non-branch
    clr();
    id_ex_dst = 5'd3; id_ex_write = 1; id_ex_memread = 1;
    id_rs = 5'd3; id_use_rs = 1; id_rt = 5'd4; id_use_rt = 1;
    #1 chk_stall("ldu.c0", 1'b1);
    @(negedge clk);
    id_ex_dst = 0; id_ex_write = 0; id_ex_memread = 0;
    #1 chk_stall("ldu.c1", 1'b0);
    @(negedge clk);
    chk("ldu.stall_cycles", stall_cycles, 16'd4);
    // rt named but not read
    id_ex_dst = 5'd3; id_ex_write = 1; id_ex_memread = 1;
    id_rs = 5'd1; id_use_rs = 1; id_rt = 5'd3; id_use_rt = 0;
    #1 chk_stall("ldu.rt_unused", 1'b0);
    // rt read, rs not read
    id_use_rs = 0; id_use_rt = 1;
    #1 chk_stall("ldu.rt_used", 1'b1);
    @(negedge clk);
    // ALU producer into a non-branch is forwarded
    id_ex_memread = 0;
    #1 chk_stall("alu_nobr", 1'b0);
    // EX/MEM load into a non-branch is forwarded
    clr();
    ex_mem_dst = 5'd9; ex_mem_write = 1; ex_mem_memread = 1; id_rs = 5'd9; id_use_rs = 1;
    #1 chk_stall("memld_nobr", 1'b0);
    // EX/MEM load into a branch: single stall
    id_branch = 1;
    #1 chk_stall("memld_br", 1'b1);
    @(negedge clk);
    chk("memld_br.stall_cycles", stall_cycles, 16'd6);

    // rs load in ID/EX and rt load in EX/MEM: max need (2), not summed
    clr();
    id_branch = 1; id_rs = 5'd8; id_rt = 5'd9; id_use_rs = 1; id_use_rt = 1;
    id_ex_dst = 5'd8; id_ex_write = 1; id_ex_memread = 1;
    ex_mem_dst = 5'd9; ex_mem_write = 1; ex_mem_memread = 1;
    #1 chk_stall("both.c0", 1'b1);
    @(negedge clk);
    #1 chk_stall("both.hold", 1'b1);
    @(negedge clk);
    clr();
    #1 chk_stall("both.c2", 1'b0);
    @(negedge clk);
    chk("both.stall_cycles", stall_cycles, 16'd8);

    // reset during HOLD abandons the remaining stall
    load_branch_inputs();
    #1 chk_stall("midhold.c0", 1'b1);
    @(negedge clk);
    reset = 1;
    #1 chk_stall("midhold.rst", 1'b0);
    chk("midhold.stall_cycles", stall_cycles, 16'd0);
    chk("midhold.flush_count", flush_count, 16'd0);
    #1 reset = 0;
    clr();
    id_branch = 1; branch_taken = 1;
    #1 chk_stall("midhold.run", 1'b0);
    chk("midhold.flush", {15'd0, if_id_flush}, 16'd1);
    @(negedge clk);
    chk("midhold.flush_count_after", flush_count, 16'd1);
    chk("midhold.stall_cycles_after", stall_cycles, 16'd0);

    // saturation: continuous load-use stall
    clr();
    id_ex_dst = 5'd3; id_ex_write = 1; id_ex_memread = 1; id_rs = 5'd3; id_use_rs = 1;
    repeat (65534) @(negedge clk);
    chk("sat.fffe", stall_cycles, 16'hFFFE);
    @(negedge clk);
    chk("sat.ffff", stall_cycles, 16'hFFFF);
    repeat (2) @(negedge clk);
    chk("sat.hold", stall_cycles, 16'hFFFF);
    chk("sat.flush_count", flush_count, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
